// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared constants, types and counter helper for the branch predictor
//
// Purpose : layout of the execute-stage branch-resolution record, 2-bit
//           direction counter encodings, the registered prediction bundle
//           and the saturating counter update used when training.
// Ports   : none (package)
package bpu_pkg;

  // Branch-resolution record: pc | Count | is_branch | br_taken | br_target
  localparam int BRESULT_WD   = 68;
  localparam int BR_PC_MSB    = 67;
  localparam int BR_PC_LSB    = 36;
  localparam int BR_COUNT_MSB = 35;
  localparam int BR_COUNT_LSB = 34;
  localparam int BR_IS_BRANCH = 33;
  localparam int BR_TAKEN     = 32;
  localparam int BR_TARGET_MSB = 31;
  localparam int BR_TARGET_LSB = 0;

  // 2-bit direction counter encodings
  localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

  // Registered prediction presented to the pre-IF stage
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  count;
  } pred_t;

  // Saturating step of a direction counter toward the resolved outcome
  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'b01;
    end
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/btb_array.sv
// rtl/btb_array.sv - flop-based BTB storage with one read port, one write port and write-forwarding
//
// Purpose : holds valid/tag/target/cnt per entry. The write port carries a
//           branch allocation or an alias scrub; the array resolves the
//           target-keep and scrub decisions against the stored entry so the
//           forwarded read data is exactly what will be stored.
// Ports   : clk, resetn           - clock, async active-low clear
//           rd_index              - lookup index (combinational read)
//           rd_valid/rd_tag/rd_target/rd_cnt - entry contents, post-write when
//                                   the write hits the same index this cycle
//           wr_en                 - apply a write this edge
//           wr_alloc              - 1: branch allocate/train, 0: alias scrub
//           wr_taken              - resolved direction (forces target write)
//           wr_index/wr_tag/wr_cnt/wr_target - write payload
module btb_array
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_target,
  output logic [1:0]         rd_cnt,
  input  logic               wr_en,
  input  logic               wr_alloc,
  input  logic               wr_taken,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [1:0]         wr_cnt,
  input  logic [31:0]        wr_target
);

  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];

  logic               wr_hit;
  logic               nx_valid;
  logic [TAG_W-1:0]   nx_tag;
  logic [31:0]        nx_target;
  logic [1:0]         nx_cnt;
  logic               fwd;

  // Next contents of the addressed entry; equals the stored entry when the
  // write turns out to be a no-op (scrub of a non-matching entry).
  always_comb begin
    wr_hit    = valid_q[wr_index] && (tag_q[wr_index] == wr_tag);
    nx_valid  = valid_q[wr_index];
    nx_tag    = tag_q[wr_index];
    nx_target = target_q[wr_index];
    nx_cnt    = cnt_q[wr_index];
    if (wr_alloc) begin
      nx_valid = 1'b1;
      nx_tag   = wr_tag;
      nx_cnt   = wr_cnt;
      // A not-taken resolution on the same branch keeps the learned target.
      if (wr_taken || !wr_hit) begin
        nx_target = wr_target;
      end
    end else if (wr_hit) begin
      nx_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_index]  <= nx_valid;
      tag_q[wr_index]    <= nx_tag;
      target_q[wr_index] <= nx_target;
      cnt_q[wr_index]    <= nx_cnt;
    end
  end

  // Lookup on the same edge as a write to the same index sees the new entry.
  assign fwd       = wr_en && (wr_index == rd_index);
  assign rd_valid  = fwd ? nx_valid  : valid_q[rd_index];
  assign rd_tag    = fwd ? nx_tag    : tag_q[rd_index];
  assign rd_target = fwd ? nx_target : target_q[rd_index];
  assign rd_cnt    = fwd ? nx_cnt    : cnt_q[rd_index];

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB with 2-bit direction counters, trained by the execute-stage resolution record
//
// Purpose : one-cycle taken/target prediction for the pre-IF stage, trained
//           from EXE_BResult using the counter value issued at prediction.
// Ports   : clk, resetn           - clock, async active-low reset
//           lookup_valid/lookup_pc/lookup_stall - fetch PC request and hold
//           pred_valid/pred_taken/pred_target/pred_count - registered prediction
//           bresult_valid/EXE_BResult - resolved instruction record from execute
module branch_predictor
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  input  logic                  lookup_stall,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [31:0]           pred_target,
  output logic [1:0]            pred_count,
  input  logic                  bresult_valid,
  input  logic [BRESULT_WD-1:0] EXE_BResult
);

  // Update decode
  logic [31:0]        br_pc;
  logic [1:0]         br_count;
  logic               br_is_branch;
  logic               br_taken;
  logic [31:0]        br_target;
  logic [INDEX_W-1:0] upd_index;
  logic [TAG_W-1:0]   upd_tag;
  logic [1:0]         upd_cnt;

  assign br_pc        = EXE_BResult[BR_PC_MSB:BR_PC_LSB];
  assign br_count     = EXE_BResult[BR_COUNT_MSB:BR_COUNT_LSB];
  assign br_is_branch = EXE_BResult[BR_IS_BRANCH];
  assign br_taken     = EXE_BResult[BR_TAKEN];
  assign br_target    = EXE_BResult[BR_TARGET_MSB:BR_TARGET_LSB];
  assign upd_index    = br_pc[INDEX_W+1:2];
  assign upd_tag      = br_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  // Train from the carried Count, not the stored cnt, so back-to-back
  // resolutions of the same branch each apply their own step.
  assign upd_cnt      = cnt_step(br_count, br_taken);

  // Lookup side
  logic [INDEX_W-1:0] lk_index;
  logic [TAG_W-1:0]   lk_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_target;
  logic [1:0]         rd_cnt;
  logic               lk_hit;

  assign lk_index = lookup_pc[INDEX_W+1:2];
  assign lk_tag   = lookup_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign lk_hit   = rd_valid && (rd_tag == lk_tag);

  // PC bits outside index/tag do not take part in prediction.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc, br_pc};

  btb_array #(
    .ENTRIES (ENTRIES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk       (clk),
    .resetn    (resetn),
    .rd_index  (lk_index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_cnt    (rd_cnt),
    .wr_en     (bresult_valid),
    .wr_alloc  (br_is_branch),
    .wr_taken  (br_taken),
    .wr_index  (upd_index),
    .wr_tag    (upd_tag),
    .wr_cnt    (upd_cnt),
    .wr_target (br_target)
  );

  // Prediction register
  pred_t pred_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_q <= '{valid: 1'b0, taken: 1'b0, target: 32'h0, count: CNT_WNT};
    end else if (!lookup_stall) begin
      if (lookup_valid) begin
        pred_q.valid  <= lk_hit;
        pred_q.taken  <= lk_hit && rd_cnt[1];
        pred_q.target <= rd_target;
        pred_q.count  <= lk_hit ? rd_cnt : CNT_WNT;
      end else begin
        pred_q <= '{valid: 1'b0, taken: 1'b0, target: 32'h0, count: CNT_WNT};
      end
    end
  end

  assign pred_valid  = pred_q.valid;
  assign pred_taken  = pred_q.taken;
  assign pred_target = pred_q.target;
  assign pred_count  = pred_q.count;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = 32'h0;
  logic        lookup_stall = 1'b0;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_count;
  logic        bresult_valid = 1'b0;
  logic [67:0] EXE_BResult = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .resetn        (resetn),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .lookup_stall  (lookup_stall),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .pred_count    (pred_count),
    .bresult_valid (bresult_valid),
    .EXE_BResult   (EXE_BResult)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a table keyed by index, outcome rules applied directly.
  bit        m_v   [64];
  bit [7:0]  m_tag [64];
  bit [31:0] m_tgt [64];
  int        m_cnt [64];
  bit        e_valid;
  bit        e_taken;
  bit [31:0] e_target;
  int        e_count;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 64; i++) begin
        m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
      end
      e_valid = 0; e_taken = 0; e_target = 0; e_count = 1;
    end else begin
      if (bresult_valid) begin
        int idx;
        bit [7:0] tg;
        bit same;
        idx  = int'(EXE_BResult[67:36] >> 2) % 64;
        tg   = EXE_BResult[67:36] >> 8;
        same = m_v[idx] && (m_tag[idx] == tg);
        if (EXE_BResult[33]) begin
          int c;
          c = int'(EXE_BResult[35:34]);
          if (EXE_BResult[32]) c = (c + 1 > 3) ? 3 : c + 1;
          else                 c = (c - 1 < 0) ? 0 : c - 1;
          if (EXE_BResult[32] || !same) m_tgt[idx] = EXE_BResult[31:0];
          m_v[idx] = 1; m_tag[idx] = tg; m_cnt[idx] = c;
        end else if (same) begin
          m_v[idx] = 0;
        end
      end
      if (!lookup_stall) begin
        if (lookup_valid) begin
          int li;
          li       = int'(lookup_pc >> 2) % 64;
          e_valid  = m_v[li] && (m_tag[li] == 8'(lookup_pc >> 8));
          e_taken  = e_valid && (m_cnt[li] >= 2);
          e_target = m_tgt[li];
          e_count  = e_valid ? m_cnt[li] : 1;
        end else begin
          e_valid = 0; e_taken = 0; e_target = 0; e_count = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      chk("model_valid",  {31'b0, pred_valid},  {31'b0, e_valid});
      chk("model_taken",  {31'b0, pred_taken},  {31'b0, e_taken});
      chk("model_target", pred_target,          e_target);
      chk("model_count",  {30'b0, pred_count},  32'(e_count));
    end
  end

  task automatic expect_pred(input string nm, input logic v, input logic t,
                             input logic [31:0] tgt, input logic [1:0] c);
    chk({nm, "_valid"},  {31'b0, pred_valid},  {31'b0, v});
    chk({nm, "_taken"},  {31'b0, pred_taken},  {31'b0, t});
    chk({nm, "_target"}, pred_target,          tgt);
    chk({nm, "_count"},  {30'b0, pred_count},  {30'b0, c});
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [1:0] cnt, input logic isb,
                           input logic tk, input logic [31:0] tgt);
    bresult_valid = 1'b1;
    EXE_BResult   = {pc, cnt, isb, tk, tgt};
    @(negedge clk);
    bresult_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    @(negedge clk);
    lookup_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    expect_pred("reset", 1'b0, 1'b0, 32'h0, 2'b01);
    resetn = 1'b1;

    // Cold miss after reset
    do_lookup(32'hBFC0_0000);
    expect_pred("cold_miss", 1'b0, 1'b0, 32'h0, 2'b01);

    // First allocation, taken from weakly not-taken
    do_update(32'hBFC0_0010, 2'b01, 1'b1, 1'b1, 32'hBFC0_0100);
    do_lookup(32'hBFC0_0010);
    expect_pred("alloc", 1'b1, 1'b1, 32'hBFC0_0100, 2'b10);

    // Saturation at strongly taken
    do_update(32'hBFC0_0010, 2'b11, 1'b1, 1'b1, 32'hBFC0_0100);
    do_update(32'hBFC0_0010, 2'b11, 1'b1, 1'b1, 32'hBFC0_0100);
    do_lookup(32'hBFC0_0010);
    expect_pred("sat_hi", 1'b1, 1'b1, 32'hBFC0_0100, 2'b11);

    // Saturation at strongly not-taken; target kept on not-taken hit
    do_update(32'hBFC0_0010, 2'b00, 1'b1, 1'b0, 32'h1111_2222);
    do_lookup(32'hBFC0_0010);
    expect_pred("sat_lo", 1'b1, 1'b0, 32'hBFC0_0100, 2'b00);

    // Alias: same index, different tag
    do_lookup(32'hBFC0_0410);
    expect_pred("alias_miss", 1'b0, 1'b0, 32'hBFC0_0100, 2'b01);
    do_update(32'hBFC0_0410, 2'b10, 1'b0, 1'b0, 32'h0);
    do_lookup(32'hBFC0_0010);
    expect_pred("alias_keep", 1'b1, 1'b0, 32'hBFC0_0100, 2'b00);
    do_update(32'hBFC0_0010, 2'b00, 1'b0, 1'b0, 32'h0);
    do_lookup(32'hBFC0_0010);
    expect_pred("scrubbed", 1'b0, 1'b0, 32'hBFC0_0100, 2'b01);

    // Same-edge update and lookup: forwarded
    bresult_valid = 1'b1;
    EXE_BResult   = {32'h8000_0020, 2'b01, 1'b1, 1'b1, 32'h8000_0400};
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h8000_0020;
    @(negedge clk);
    bresult_valid = 1'b0;
    lookup_valid  = 1'b0;
    expect_pred("forward", 1'b1, 1'b1, 32'h8000_0400, 2'b10);

    // Back-to-back updates use their own carried Count
    do_update(32'h8000_0020, 2'b11, 1'b1, 1'b1, 32'h8000_0800);
    do_update(32'h8000_0020, 2'b00, 1'b1, 1'b0, 32'h1234_5678);
    do_lookup(32'h8000_0020);
    expect_pred("b2b", 1'b1, 1'b0, 32'h8000_0800, 2'b00);

    // New tag, not taken: target replaced since the tag differs
    do_update(32'h8000_0120, 2'b01, 1'b1, 1'b0, 32'hAAAA_0000);
    do_lookup(32'h8000_0120);
    expect_pred("retag", 1'b1, 1'b0, 32'hAAAA_0000, 2'b00);

    // Stall holds outputs while the entry is retrained
    lookup_stall = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h8000_0020;
    for (int k = 0; k < 3; k++) begin
      do_update(32'h8000_0120, 2'(k), 1'b1, 1'b1, 32'hCCCC_0000);
      expect_pred("stall_hold", 1'b1, 1'b0, 32'hAAAA_0000, 2'b00);
    end

    // Asynchronous reset mid-stall
    #2;
    resetn = 1'b0;
    #1;
    expect_pred("async_rst", 1'b0, 1'b0, 32'h0, 2'b01);
    @(negedge clk);
    @(negedge clk);
    resetn       = 1'b1;
    lookup_stall = 1'b0;
    lookup_valid = 1'b0;
    do_lookup(32'h8000_0120);
    expect_pred("post_rst", 1'b0, 1'b0, 32'h0, 2'b01);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch target buffer with 2-bit saturating direction counters. It serves taken/target predictions to the pre-IF stage and is trained by the branch-resolution record that the execute stage emits on `EXE_BResult`. This block is the receiving end of that record. The `Count` field the execute stage carries back is the counter value this block issued at prediction time.

## Interface
Parameters:
- `ENTRIES`, 64: number of BTB entries; must be a power of two.
- `INDEX_W`, 6: log2(`ENTRIES`).
- `TAG_W`, 8: number of PC tag bits stored per entry.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `lookup_valid`  in  1  the pre-IF stage presents a fetch PC this cycle.
- `lookup_pc`  in  32  fetch PC to predict.
- `lookup_stall`  in  1  hold the current prediction outputs.
- `pred_valid`  out  1  the previous lookup hit a valid entry with matching tag.
- `pred_taken`  out  1  predicted taken.
- `pred_target`  out  32  predicted target address.
- `pred_count`  out  2  counter value issued; travels down the pipe and returns as `Count`.
- `bresult_valid`  in  1  `EXE_BResult` carries a resolved instruction this cycle (execute stage valid and ready_go).
- `EXE_BResult`  in  68  fields: pc[67:36], Count[35:34], is_branch[33], br_taken[32], br_target[31:0].

## Operation
Address fields:
- index = pc[INDEX_W+1:2].
- tag = pc[INDEX_W+TAG_W+1:INDEX_W+2].

Entry contents: valid, tag, target[31:0], cnt[1:0].

Lookup:
- Captures on the edge where `lookup_valid && !lookup_stall`.
- Next cycle:
  - `pred_valid` = entry.valid && tag match.
  - `pred_taken` = `pred_valid` && cnt[1].
  - `pred_target` = entry.target.
  - `pred_count` = cnt on a hit, 2'b01 on a miss.
- If `lookup_valid` = 0 and `lookup_stall` = 0, all outputs go to 0 next cycle (`pred_count` = 2'b01).
- While `lookup_stall` = 1, all outputs hold.

Update, on an edge with `bresult_valid` = 1:
- When is_branch = 1, write the entry at index(pc):
  - valid = 1.
  - tag = tag(pc).
  - cnt = Count+1 if br_taken, else Count-1, saturating at 2'b11 and 2'b00.
  - target = br_target only if br_taken, or if the entry was invalid or had a different tag. Otherwise the target is kept.
- When is_branch = 0 and the entry at index(pc) is valid with matching tag, clear valid (alias scrub). Otherwise there is no change.
- When `bresult_valid` = 0, there is no state change.

Same-edge collision:
- A lookup and an update on the same index in the same cycle: the lookup result reflects the post-update entry (write-forward).
- Tag comparison uses the new tag.

Counter encoding:
- 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.

## Timing
- Lookup latency is exactly 1 cycle, from the capturing edge to valid outputs.
- An update is visible to a lookup captured on the same edge via forwarding. It is stored for all later lookups.
- Reset values (asserted asynchronously, at any time, including mid-update or mid-stall):
  - Every entry: valid = 0, cnt = 2'b01, tag = 0, target = 0.
  - `pred_valid` = 0, `pred_taken` = 0, `pred_target` = 0, `pred_count` = 2'b01.
- After `resetn` deasserts, the first capturing edge produces a miss prediction.
- One update per cycle at most. Back-to-back updates to the same index apply in order; the second uses its own carried Count, not the stored cnt.

## Structure
Shared package `bpu_pkg`:
- `BRESULT_WD` = 68 and the field offsets (`BR_PC_MSB`/`BR_PC_LSB`, `BR_COUNT_*`, `BR_IS_BRANCH`, `BR_TAKEN`, `BR_TARGET_*`).
- Counter encodings `CNT_SNT`, `CNT_WNT`, `CNT_WT`, `CNT_ST`.
- Saturating-increment/decrement function.

Sub-module `btb_array`:
- Flop-based storage with async clear.
- One combinational read port and one write port.
- Contains the forwarding mux.

`branch_predictor` contains the lookup register, the update decode and the output muxing.

## Test plan
1. Reset then lookup 0xBFC00000 → next cycle `pred_valid`=0, `pred_taken`=0, `pred_count`=01.
2. Update pc=0xBFC00010, Count=01, is_branch=1, taken=1, target=0xBFC00100; then lookup 0xBFC00010 → `pred_valid`=1, `pred_taken`=1, target=0xBFC00100, `pred_count`=10.
3. Saturation:
   - Two updates with Count=11, taken → cnt stays 11.
   - Update with Count=00, not-taken → cnt stays 00, `pred_taken`=0 on hit.
4. Alias case: lookup 0xBFC00410 (same index as case 2, different tag) → miss. Then update it with is_branch=0 → entry for 0xBFC00010 is unaffected. Update 0xBFC00010 with is_branch=0 → subsequent lookup misses.
5. Same-cycle update and lookup of pc 0x80000020 (taken, target 0x80000400) → prediction next cycle shows hit, taken, 0x80000400.
6. Hold `lookup_stall`=1 for 3 cycles while updates change the entry → outputs unchanged. Assert `resetn`=0 mid-stall → all outputs reset immediately.
